uart_tx_arbiter: RTL
====================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 16'd0: idle clock cycles inserted between the end of one byte and the next start.
REQ-002 clock_50M  input  1  system clock, 50 MHz.
REQ-003 n_rst  input  1  reset, asynchronous, active-low.
REQ-004 req  input  4  per-requester byte request, level; bit i belongs to requester i.
REQ-005 req_data  input  32  requester i byte on req_data[8i+7:8i]; held stable while req[i]=1 and ack[i] not yet seen.
REQ-006 req_last  input  4  last byte of packet flag per requester; present only when UART_ARB_LOCK_EN is defined.
REQ-007 ack  output  4  one-cycle pulse on bit i when requester i byte is captured.
REQ-008 owner  output  2  index of the requester currently granted or last granted.
REQ-009 busy  output  1  1 while a byte is in flight or a gap is running.
REQ-010 uart_start  output  1  start strobe to the UART transmitter.
REQ-011 uart_data  output  8  byte to the UART transmitter, registered.
REQ-012 uart_ready  input  1  transmitter ready (1 = idle, accepts start).

Function
REQ-013 States: IDLE, START, WAIT, GAP; one-hot or binary encoding is free.
REQ-014 IDLE: if uart_ready=1 and any req bit set, select a winner, latch its byte into uart_data, pulse ack[winner], load owner, go to START in the same edge.
REQ-015 Arbitration: round-robin, search starts at owner+1 modulo 4, wraps 3->0; first set req bit wins.
REQ-016 START: uart_start=1 for exactly one cycle, then go to WAIT.
REQ-017 WAIT: stay until uart_ready=1; then go to GAP if GAP_CYCLES>0, else IDLE.
REQ-018 GAP: count GAP_CYCLES cycles with a 16-bit counter, then go to IDLE.
REQ-019 uart_start SHALL never be asserted outside START; at most one byte in flight.
REQ-020 Latency: req seen in IDLE -> ack same edge -> uart_start next cycle (1 cycle).
REQ-021 Back-to-back bytes from the same single requester SHALL be accepted with no gap beyond GAP_CYCLES and one IDLE cycle.
REQ-022 A requester dropping req before ack SHALL lose its request with no ack and no side effects.
REQ-023 req bits changing during START/WAIT/GAP SHALL be ignored until the next IDLE.
REQ-024 busy = 1 in START, WAIT, GAP; 0 in IDLE.
REQ-025 uart_ready=0 in IDLE (external use of the transmitter) SHALL hold the arbiter in IDLE without ack.

Reset
REQ-026 On n_rst=0, asynchronously: state=IDLE, ack=0, uart_start=0, uart_data=8'h00, owner=2'd3 (so requester 0 has first priority), busy=0, gap counter=0, lock flag=0.
REQ-027 Reset mid-byte SHALL abandon the byte with no ack retry; the requester re-requests after reset.

Configuration
REQ-028 Macro UART_ARB_LOCK_EN: when defined, req_last exists and a lock flag is set on ack of a byte with req_last[owner]=0.
REQ-029 With UART_ARB_LOCK_EN and lock set: IDLE grants only owner; lock clears on ack of a byte with req_last=1, or when req[owner]=0 in IDLE.
REQ-030 Without UART_ARB_LOCK_EN: no req_last port, no lock flag, every byte re-arbitrated per REQ-015.

Verification
REQ-031 Reset, req=4'b0001, req_data[7:0]=8'h41, model uart_tx -> ack=4'b0001 once, uart_start one cycle later, uart_data=8'h41, busy until uart_ready=1.
REQ-032 req=4'b1111 held, bytes 8'h10/8'h20/8'h30/8'h40 -> grant order 0,1,2,3,0 (wrap), one ack per byte.
REQ-033 GAP_CYCLES=16'd5, two bytes from requester 2 -> exactly 5 GAP cycles + 1 IDLE cycle between uart_ready rising and second uart_start.
REQ-034 uart_ready forced 0 in IDLE with req=4'b0100 -> no ack, no uart_start until uart_ready=1.
REQ-035 UART_ARB_LOCK_EN, req=4'b0011, requester 0 sends 3 bytes with req_last=0,0,1 -> all three granted to 0 before requester 1; without macro -> grants alternate 0,1,0,1.
REQ-036 n_rst pulsed low during WAIT -> all outputs at reset values immediately, next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter feeding one UART transmitter from four
// byte requesters. One byte is in flight at a time; an optional idle gap of
// GAP_CYCLES clocks follows each byte.
// Optional feature: define UART_ARB_LOCK_EN to add req_last and packet locking,
// which keeps the grant on one requester until it flags its last byte.
module uart_tx_arbiter #(
    parameter logic [15:0] GAP_CYCLES = 16'd0
) (
    input  logic        clock_50M,
    input  logic        n_rst,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [3:0]  req_last,
`endif
    output logic [3:0]  ack,
    output logic [1:0]  owner,
    output logic        busy,
    output logic        uart_start,
    output logic [7:0]  uart_data,
    input  logic        uart_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t      state;
    logic [15:0] gap_cnt;
    logic [3:0]  eligible;
    logic        grant_valid;
    logic [1:0]  grant_idx;
    logic [7:0]  grant_byte;

`ifdef UART_ARB_LOCK_EN
    logic        lock;

    // While locked and the owner still requests, only the owner may win.
    always_comb begin
        eligible = req;
        if (lock && req[owner]) begin
            eligible = 4'b0001 << owner;
        end
    end
`else
    // Every byte is re-arbitrated among all requesters.
    always_comb begin
        eligible = req;
    end
`endif

    // Round-robin search from owner+1, wrapping 3->0; the owner itself is
    // checked last (offset 4 wraps back to owner).
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = owner;
        for (int unsigned i = 1; i <= 4; i++) begin
            if (!grant_valid && eligible[owner + 2'(i)]) begin
                grant_valid = 1'b1;
                grant_idx   = owner + 2'(i);
            end
        end
        grant_byte = req_data[{grant_idx, 3'b000} +: 8];
    end

    // Control FSM with registered ack/start/data/owner/busy outputs.
    // ack and uart_start are both raised on the capture edge so that
    // uart_start is only ever high during the START cycle; the transmitter
    // is expected to drop uart_ready the cycle after it sees uart_start.
    always_ff @(posedge clock_50M or negedge n_rst) begin
        if (!n_rst) begin
            state      <= IDLE;
            ack        <= '0;
            uart_start <= 1'b0;
            uart_data  <= 8'h00;
            owner      <= 2'd3;
            busy       <= 1'b0;
            gap_cnt    <= '0;
`ifdef UART_ARB_LOCK_EN
            lock       <= 1'b0;
`endif
        end else begin
            ack        <= '0;
            uart_start <= 1'b0;
            case (state)
                IDLE: begin
`ifdef UART_ARB_LOCK_EN
                    // Owner abandoned its packet: release the lock.
                    if (lock && !req[owner]) begin
                        lock <= 1'b0;
                    end
`endif
                    if (uart_ready && grant_valid) begin
                        ack        <= 4'b0001 << grant_idx;
                        uart_data  <= grant_byte;
                        owner      <= grant_idx;
                        uart_start <= 1'b1;
                        busy       <= 1'b1;
                        state      <= START;
`ifdef UART_ARB_LOCK_EN
                        lock       <= ~req_last[grant_idx];
`endif
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (uart_ready) begin
                        if (GAP_CYCLES != 16'd0) begin
                            state   <= GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_CYCLES - 16'd1) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
